lab03_debounce: RTL and testbench

LAB03_DEBOUNCE -- requirements
Module: lab03_debounce

---
 rtl/lab03_pkg.sv | 13 +
 rtl/lab03_sync2.sv | 24 ++
 rtl/lab03_debounce.sv | 130 +++++++++++++
 tb/tb_lab03_debounce.sv | 129 ++++++++++++
 4 files changed

// File: rtl/lab03_pkg.sv
// Shared FSM state encoding and default stability length for the lab03 debouncer.
package lab03_pkg;

   typedef enum logic [1:0] {
      IDLE_LO = 2'b00,
      CHK_HI  = 2'b01,
      IDLE_HI = 2'b10,
      CHK_LO  = 2'b11
   } state_e;

   localparam int STABLE_CYCLES_DEFAULT = 4;

endpackage : lab03_pkg

// File: rtl/lab03_sync2.sv
// Two-flop synchronizer for one asynchronous level; two edges latency, clears to 0 on reset.
module lab03_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d;
         s2_q <= s1_q;
      end
   end

   assign q = s2_q;

endmodule : lab03_sync2

// File: rtl/lab03_debounce.sv
// Debounces a raw switch level: out changes STABLE_CYCLES+1 edges after s1 captures a new level
// held steady; rise/fall pulse for one cycle on the accepting edge.
module lab03_debounce
   import lab03_pkg::*;
#(
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in1,
   output logic out,
   output logic nout,
   output logic rise,
   output logic fall
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             s2;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_q, out_d;
   logic             nout_q, nout_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   lab03_sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (in1),
      .q     (s2)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE_LO;
         cnt_q   <= '0;
         out_q   <= 1'b0;
         nout_q  <= 1'b1;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         nout_q  <= nout_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      unique case (state_q)
         IDLE_LO: begin
            out_d = 1'b0;
            cnt_d = '0;
            if (s2) begin
               // A one-sample window accepts immediately, no check state needed.
               if (STABLE_CYCLES == 1) begin
                  state_d = IDLE_HI;
                  out_d   = 1'b1;
                  rise_d  = 1'b1;
               end else begin
                  state_d = CHK_HI;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         CHK_HI: begin
            if (!s2) begin
               state_d = IDLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_HI;
               cnt_d   = '0;
               out_d   = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         IDLE_HI: begin
            out_d = 1'b1;
            cnt_d = '0;
            if (!s2) begin
               if (STABLE_CYCLES == 1) begin
                  state_d = IDLE_LO;
                  out_d   = 1'b0;
                  fall_d  = 1'b1;
               end else begin
                  state_d = CHK_LO;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         CHK_LO: begin
            if (s2) begin
               state_d = IDLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_LO;
               cnt_d   = '0;
               out_d   = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE_LO;
            cnt_d   = '0;
            out_d   = 1'b0;
         end
      endcase
      nout_d = ~out_d;
   end

   assign out  = out_q;
   assign nout = nout_q;
   assign rise = rise_q;
   assign fall = fall_q;

endmodule : lab03_debounce

// File: tb/tb_lab03_debounce.sv
// Directed checks of the debouncer: a per-edge vector table for the default window and a short
// hand-written sequence for the single-sample window.
module tb_lab03_debounce;

   typedef struct {
      logic rst_n;
      logic in1;
      logic exp_out;
      logic exp_rise;
      logic exp_fall;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic in1_a, in1_b;
   logic out_a, nout_a, rise_a, fall_a;
   logic out_b, nout_b, rise_b, fall_b;

   int total = 0;
   int bad   = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   lab03_debounce #(.STABLE_CYCLES(4)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .in1   (in1_a),
      .out   (out_a),
      .nout  (nout_a),
      .rise  (rise_a),
      .fall  (fall_a)
   );

   lab03_debounce #(.STABLE_CYCLES(1)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .in1   (in1_b),
      .out   (out_b),
      .nout  (nout_b),
      .rise  (rise_b),
      .fall  (fall_b)
   );

   task automatic check(input string name, input int step, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step %0d: got %b want %b", name, step, act, exp);
      end
   endtask

   task automatic push(input logic r, input logic i, input logic o, input logic ri,
                       input logic fa, input int n);
      vec_t v;
      v.rst_n = r; v.in1 = i; v.exp_out = o; v.exp_rise = ri; v.exp_fall = fa;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endtask

   task automatic step_b(input logic i, input int step, input logic o, input logic ri,
                         input logic fa);
      in1_b = i;
      @(posedge clk);
      #1;
      check("n1_out",  step, out_b,  o);
      check("n1_nout", step, nout_b, ~o);
      check("n1_rise", step, rise_b, ri);
      check("n1_fall", step, fall_b, fa);
   endtask

   initial begin
      rst_n = 1'b0;
      in1_a = 1'b1;
      in1_b = 1'b0;

      // Each row is one rising edge; expectations are the outputs right after that edge.
      push(0, 1, 0, 0, 0, 3);                     // reset held with in1 high
      push(1, 1, 0, 0, 0, 5); push(1, 1, 1, 1, 0, 1); push(1, 1, 1, 0, 0, 2);
      push(1, 0, 1, 0, 0, 5); push(1, 0, 0, 0, 1, 1); push(1, 0, 0, 0, 0, 2);
      // rising bounce: 1,1,0 then 1 held
      push(1, 1, 0, 0, 0, 2); push(1, 0, 0, 0, 0, 1);
      push(1, 1, 0, 0, 0, 5); push(1, 1, 1, 1, 0, 1); push(1, 1, 1, 0, 0, 2);
      // falling bounce: 0,0,1 then 0 held
      push(1, 0, 1, 0, 0, 2); push(1, 1, 1, 0, 0, 1);
      push(1, 0, 1, 0, 0, 5); push(1, 0, 0, 0, 1, 1); push(1, 0, 0, 0, 0, 2);
      // reset while CHK_HI has cnt=2, then full re-acceptance
      push(1, 1, 0, 0, 0, 4); push(0, 1, 0, 0, 0, 1);
      push(1, 1, 0, 0, 0, 5); push(1, 1, 1, 1, 0, 1); push(1, 1, 1, 0, 0, 1);
      // reset on the would-be acceptance edge
      push(1, 0, 1, 0, 0, 5); push(1, 0, 0, 0, 1, 1); push(1, 0, 0, 0, 0, 1);
      push(1, 1, 0, 0, 0, 5); push(0, 1, 0, 0, 0, 1);
      push(1, 1, 0, 0, 0, 5); push(1, 1, 1, 1, 0, 1); push(1, 1, 1, 0, 0, 1);

      for (int s = 0; s < vecs.size(); s++) begin
         rst_n = vecs[s].rst_n;
         in1_a = vecs[s].in1;
         @(posedge clk);
         #1;
         check("out",  s, out_a,  vecs[s].exp_out);
         check("nout", s, nout_a, ~vecs[s].exp_out);
         check("rise", s, rise_a, vecs[s].exp_rise);
         check("fall", s, fall_a, vecs[s].exp_fall);
         check("n1_idle", s, out_b, 1'b0);
      end

      // Single-sample window: out follows each held toggle two edges later.
      rst_n = 1'b1;
      for (int t = 0; t < 4; t++) begin
         logic lvl;
         lvl = (t % 2 == 0);
         step_b(lvl, 100 + t * 4 + 0, ~lvl, 1'b0, 1'b0);
         step_b(lvl, 100 + t * 4 + 1, ~lvl, 1'b0, 1'b0);
         step_b(lvl, 100 + t * 4 + 2, lvl, lvl, ~lvl);
         step_b(lvl, 100 + t * 4 + 3, lvl, 1'b0, 1'b0);
      end

      // Single-sample window: a 2-cycle high pulse is passed through, delayed by 2 edges.
      step_b(1'b1, 200, 1'b0, 1'b0, 1'b0);
      step_b(1'b1, 201, 1'b0, 1'b0, 1'b0);
      step_b(1'b0, 202, 1'b1, 1'b1, 1'b0);
      step_b(1'b0, 203, 1'b1, 1'b0, 1'b0);
      step_b(1'b0, 204, 1'b0, 1'b0, 1'b1);
      step_b(1'b0, 205, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_lab03_debounce
